fpu_req_sequencer: RTL
======================

# fpu_req_sequencer

Issue-side sequencer for the floating-point unit. Accepts one operation at a time over a valid/ready request port, drives the FPU's op-mode and operand inputs and holds them stable for the selected unit's pipeline depth, captures the FPU result, and returns it with its tag over a valid/ready response port. The FPU's output mux follows the live op-mode, so exactly one operation is in flight and inputs stay frozen until capture.

## Interface
Parameters:
- LAT_ADDSUB, default 3: cycles from operand launch to a valid add/sub result. Legal range 1..31.
- LAT_MUL, default 3: the same for multiply. Legal range 1..31.
- LAT_DIV, default 8: the same for divide. Legal range 1..31.
- TAG_W, default 4: width of the request/response tag.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset; reset==0 at a rising edge resets the block.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_op  in  2  00 add, 01 sub, 10 mul, 11 div.
- req_a, req_b  in  32  IEEE-754 single operands; division computes a/b.
- req_tag  in  TAG_W  opaque ID, returned with the result.
- fpu_op_mode  out  2  to FPU op_mode.
- fpu_a, fpu_b  out  32  to FPU a, b.
- fpu_result  in  32  from FPU result.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_result  out  32  captured FPU result.
- rsp_tag  out  TAG_W  tag of the completed request.
- rsp_op  out  2  op of the completed request.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. If req_valid, the request is accepted: register req_op, req_a, req_b and req_tag, then go to WAIT.
- On acceptance, load the 5-bit down-counter with LAT(op)-1. Select LAT_ADDSUB for ops 00 and 01, LAT_MUL for 10, and LAT_DIV for 11.
- WAIT: the counter decrements each cycle. At the edge where the counter reads 0:
  - rsp_result <= fpu_result
  - rsp_tag and rsp_op are loaded from the stored request
  - rsp_valid <= 1
  - state goes to RESP
- RESP: hold every rsp_* output stable while rsp_valid && !rsp_ready. On rsp_valid && rsp_ready, clear rsp_valid and go to IDLE.
- fpu_op_mode, fpu_a and fpu_b are driven directly from the operand registers. They change only on an acceptance edge, so they are constant through WAIT, RESP and the following IDLE.
- req_valid and the req_* inputs are ignored outside IDLE; there is no queuing.
- No arithmetic is done in this block; results pass through bit-exact.

## Timing
- Reset (reset==0 at an edge): state becomes IDLE, the counter becomes 0, and these outputs go to 0:
  - fpu_op_mode, fpu_a, fpu_b
  - rsp_valid, rsp_result, rsp_tag, rsp_op
- req_ready is 0 while reset==0 and 1 in the first cycle after reset is released.
- Reset mid-operation (WAIT or RESP): the in-flight operation is discarded with no response, and the block is in IDLE the next cycle.
- Cycle timing for an acceptance at edge E0:
  - fpu_* inputs present the new operands from E0 onward.
  - fpu_result is captured at edge E0+LAT.
  - rsp_valid is high after E0+LAT.
- Response handshake: with rsp_ready held high, the handshake happens at edge E0+LAT+1.
  - req_ready is high after that edge.
  - The earliest next acceptance is edge E0+LAT+2, so back-to-back throughput is one op per LAT+2 cycles.
- Backpressure: each cycle of rsp_ready low in RESP adds one cycle. Nothing is lost.
- If req_valid and reset==0 occur at the same edge, reset wins and the request is not accepted.

## Test plan
- Add. Send op 00, a=0x3FC00000, b=0x40100000, tag 1 into the real FPU. Expect rsp_result=0x40700000, tag 1, op 00, with rsp_valid rising exactly LAT_ADDSUB cycles after acceptance.
- Subtract. Send op 01, a=0x40A00000, b=0x3F800000, tag 2. Expect 0x40800000 and tag 2.
- Multiply. Send op 10, a=0x40000000, b=0x40400000. Expect 0x40C00000 after LAT_MUL cycles.
- Divide. Send op 11, a=0x40C00000, b=0x40000000. Expect 0x40400000 after LAT_DIV cycles. fpu_op_mode, fpu_a and fpu_b must not change during WAIT.
- Backpressure plus back-to-back issue. Hold rsp_ready=0 for 5 cycles in RESP, with req_valid asserted continuously for a second request.
  - All rsp_* outputs must stay stable and req_ready must stay 0.
  - After the handshake, the second request is accepted exactly one cycle later and its tag is returned in order.
- Reset mid-divide. Drive reset=0 for one cycle, 3 cycles after a divide is accepted.
  - The response must never appear.
  - All outputs must read 0 after the reset edge.
  - req_ready must be 1 the following cycle, and a new add completes normally.

Source files
------------

// File: rtl/fpu_req_sequencer.sv
// Issue-side sequencer for the FPU: accepts one op, holds FPU inputs frozen
// for the selected unit's latency, captures the result and returns it tagged.
module fpu_req_sequencer #(
  parameter int LAT_ADDSUB = 3,
  parameter int LAT_MUL    = 3,
  parameter int LAT_DIV    = 8,
  parameter int TAG_W      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic [1:0]       fpu_op_mode,
  output logic [31:0]      fpu_a,
  output logic [31:0]      fpu_b,
  input  logic [31:0]      fpu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [1:0]       rsp_op
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state;
  logic [4:0]       cnt;
  logic [1:0]       op_q;
  logic [31:0]      a_q;
  logic [31:0]      b_q;
  logic [TAG_W-1:0] tag_q;
  logic [4:0]       lat_m1;

  // Counter preload: latency of the requested unit minus one
  always_comb begin
    lat_m1 = 5'(LAT_ADDSUB - 1);
    case (req_op)
      2'b10:   lat_m1 = 5'(LAT_MUL - 1);
      2'b11:   lat_m1 = 5'(LAT_DIV - 1);
      default: lat_m1 = 5'(LAT_ADDSUB - 1);
    endcase
  end

  // Ready only in IDLE and never while reset is held
  assign req_ready = reset && (state == IDLE);

  // FPU inputs come straight from the operand registers so they stay frozen
  assign fpu_op_mode = op_q;
  assign fpu_a       = a_q;
  assign fpu_b       = b_q;

  // Sequencer FSM: accept, wait out the pipeline, capture, hand off response
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      tag_q      <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_tag    <= '0;
      rsp_op     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_q  <= req_op;
            a_q   <= req_a;
            b_q   <= req_b;
            tag_q <= req_tag;
            cnt   <= lat_m1;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == 5'd0) begin
            rsp_result <= fpu_result;
            rsp_tag    <= tag_q;
            rsp_op     <= op_q;
            rsp_valid  <= 1'b1;
            state      <= RESP;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        RESP: begin
          if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
